// File: rtl/f3m_addsub_serial_if.sv
// Request/result bundle for the digit-serial GF(3^M) add/sub unit.
// The master drives start/op/A/B; the slave returns the C register and status.
interface f3m_addsub_serial_if #(
  parameter int M = 97
);
  logic           start;
  logic [1:0]     op;
  logic [2*M-1:0] A;
  logic [2*M-1:0] B;
  logic [2*M-1:0] C;
  logic           busy;
  logic           done;
  logic           err;

  modport master (output start, op, A, B, input C, busy, done, err);
  modport slave  (input start, op, A, B, output C, busy, done, err);
endinterface

// File: rtl/f3m_addsub_serial.sv
// Digit-serial GF(3^M) add / subtract / negate / accumulate, D coefficients per cycle.
// Handshake: start is taken only while busy=0; done pulses for one cycle once C is complete.
module f3m_addsub_serial #(
  parameter int M = 97,
  parameter int D = 8
) (
  input  logic                clk,
  input  logic                reset,
  f3m_addsub_serial_if.slave  bus,
  output logic                dbg_state
);
  localparam int NCHUNK = (M + D - 1) / D;
  localparam int W      = 2 * D * NCHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     op_q;
  logic [W-1:0]   a_sh, b_sh;
  logic [2*M-1:0] c_q, c_d;
  logic           done_q, err_q;
  logic           accept, step, last, bad;
  int             idx;

  // Illegal code 11 on either input yields 00.
  function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (a == 2'b11 || b == 2'b11) return 2'b00;
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Negation swaps the 1/2 codes and leaves 00 and the illegal 11 alone.
  function automatic logic [1:0] f3_sub(input logic [1:0] a, input logic [1:0] b);
    return f3_add(a, {b[0], b[1]});
  endfunction

  function automatic logic [1:0] lane_op(input logic [1:0] op, input logic [1:0] a,
                                         input logic [1:0] b);
    case (op)
      2'b00, 2'b11: return f3_add(a, b);
      2'b01:        return f3_sub(a, b);
      default:      return f3_sub(2'b00, a);
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(NCHUNK - 1)) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lanes read the low D coefficients of the shifted operands; lanes past M are dropped.
  always_comb begin
    c_d = c_q;
    bad = 1'b0;
    idx = 0;
    for (int j = 0; j < D; j++) begin
      idx = int'(cnt_q) * D + j;
      if (idx < M) begin
        c_d[2*idx +: 2] = lane_op(op_q, a_sh[2*j +: 2], b_sh[2*j +: 2]);
        if (a_sh[2*j +: 2] == 2'b11 || (op_q != 2'b10 && b_sh[2*j +: 2] == 2'b11))
          bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      op_q   <= 2'b00;
      a_sh   <= '0;
      b_sh   <= '0;
      c_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        op_q  <= bus.op;
        a_sh  <= W'(bus.A);
        // Accumulate uses a snapshot of the current result as the second operand.
        b_sh  <= (bus.op == 2'b11) ? W'(c_q) : W'(bus.B);
        cnt_q <= '0;
        err_q <= 1'b0;
      end else if (step) begin
        c_q   <= c_d;
        a_sh  <= a_sh >> (2 * D);
        b_sh  <= b_sh >> (2 * D);
        cnt_q <= cnt_q + CW'(1);
        if (bad) err_q <= 1'b1;
      end
    end
  end

  assign bus.C     = c_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_f3m_addsub_serial.sv
// Bench for f3m_addsub_serial: three instances (D=8, D=1, D=M) share stimulus.
// Directed table, randomized ops vs. a per-coefficient arithmetic model, handshake and reset sequences.
module tb_f3m_addsub_serial;
  localparam int M = 97;
  localparam int DV[3] = '{8, 1, M};

  logic           clk = 1'b0;
  logic           reset;
  logic           start, aux_en;
  logic [1:0]     op;
  logic [2*M-1:0] a, b;
  logic [2:0]     dbg;

  always #5 clk = ~clk;

  f3m_addsub_serial_if #(.M(M)) if0 ();
  f3m_addsub_serial_if #(.M(M)) if1 ();
  f3m_addsub_serial_if #(.M(M)) if2 ();

  assign if0.start = start;
  assign if1.start = start & aux_en;
  assign if2.start = start & aux_en;
  assign if0.op = op;  assign if1.op = op;  assign if2.op = op;
  assign if0.A  = a;   assign if1.A  = a;   assign if2.A  = a;
  assign if0.B  = b;   assign if1.B  = b;   assign if2.B  = b;

  f3m_addsub_serial #(.M(M), .D(8)) dut0 (.clk(clk), .reset(reset), .bus(if0), .dbg_state(dbg[0]));
  f3m_addsub_serial #(.M(M), .D(1)) dut1 (.clk(clk), .reset(reset), .bus(if1), .dbg_state(dbg[1]));
  f3m_addsub_serial #(.M(M), .D(M)) dut2 (.clk(clk), .reset(reset), .bus(if2), .dbg_state(dbg[2]));

  logic [2*M-1:0] c_v[3];
  logic           done_v[3], busy_v[3], err_v[3];
  assign c_v[0] = if0.C;  assign c_v[1] = if1.C;  assign c_v[2] = if2.C;
  assign done_v[0] = if0.done;  assign done_v[1] = if1.done;  assign done_v[2] = if2.done;
  assign busy_v[0] = if0.busy;  assign busy_v[1] = if1.busy;  assign busy_v[2] = if2.busy;
  assign err_v[0]  = if0.err;   assign err_v[1]  = if1.err;   assign err_v[2]  = if2.err;

  typedef struct {
    logic [1:0]     op;
    logic [2*M-1:0] a;
    logic [2*M-1:0] b;
    logic [2*M-1:0] exp_c;
    logic           exp_err;
  } vec_t;

  vec_t           tbl[11];
  int             checks = 0;
  int             errors = 0;
  logic [2*M-1:0] model_c;
  logic [2*M-1:0] exp_q[$];

  task automatic chk(input string name, input logic [2*M-1:0] got, input logic [2*M-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [2*M-1:0] fill(input logic [1:0] v);
    logic [2*M-1:0] r;
    for (int i = 0; i < M; i++) r[2*i +: 2] = v;
    return r;
  endfunction

  function automatic logic [2*M-1:0] set_coef(input logic [2*M-1:0] v, input int i,
                                              input logic [1:0] c);
    logic [2*M-1:0] r;
    r = v;
    r[2*i +: 2] = c;
    return r;
  endfunction

  function automatic logic [2*M-1:0] rand_vec(input int illegal_odds);
    logic [2*M-1:0] r;
    for (int i = 0; i < M; i++)
      if (illegal_odds > 0 && $urandom_range(0, illegal_odds) == 0) r[2*i +: 2] = 2'b11;
      else r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // Reference: integer arithmetic mod 3 on each coefficient value.
  task automatic model_op(input logic [1:0] mop, input logic [2*M-1:0] ma, input logic [2*M-1:0] mb,
                          input logic [2*M-1:0] cold, output logic [2*M-1:0] res, output logic e);
    int x, y, r;
    e = 1'b0;
    for (int i = 0; i < M; i++) begin
      x = int'(ma[2*i +: 2]);
      y = (mop == 2'b11) ? int'(cold[2*i +: 2]) : int'(mb[2*i +: 2]);
      if (x == 3 || (mop != 2'b10 && y == 3)) begin
        r = 0;
        e = 1'b1;
      end else begin
        case (mop)
          2'b00, 2'b11: r = (x + y) % 3;
          2'b01:        r = (x - y + 3) % 3;
          default:      r = (3 - x) % 3;
        endcase
      end
      res[2*i +: 2] = 2'(r);
    end
  endtask

  // Called at a negedge; start is held across exactly one rising edge.
  task automatic launch(input logic [1:0] lop, input logic [2*M-1:0] la, input logic [2*M-1:0] lb,
                        input logic aux);
    op = lop;  a = la;  b = lb;  aux_en = aux;  start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_main(output int lat);
    lat = -1;
    for (int cyc = 1; cyc <= 150; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (if0.done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic apply_all(input string name, input logic [1:0] lop, input logic [2*M-1:0] la,
                           input logic [2*M-1:0] lb, input logic [2*M-1:0] exp_c, input logic exp_err);
    int lat[3];
    lat = '{-1, -1, -1};
    launch(lop, la, lb, 1'b1);
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (lat[i] < 0 && done_v[i]) lat[i] = cyc;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s lat d%0d", name, DV[i]), lat[i], (M + DV[i] - 1) / DV[i]);
      chk($sformatf("%s C d%0d", name, DV[i]), c_v[i], exp_c);
      chk($sformatf("%s err d%0d", name, DV[i]), err_v[i], exp_err);
      chk($sformatf("%s busy d%0d", name, DV[i]), busy_v[i], 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*M-1:0] r, exp;
    logic           e;
    int             lat, n_done, first;

    reset = 1'b0;  start = 1'b0;  aux_en = 1'b0;  op = 2'b00;  a = '0;  b = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst C d%0d", DV[i]), c_v[i], '0);
      chk($sformatf("rst busy d%0d", DV[i]), busy_v[i], 0);
      chk($sformatf("rst done d%0d", DV[i]), done_v[i], 0);
      chk($sformatf("rst err d%0d", DV[i]), err_v[i], 0);
    end
    chk("rst dbg", dbg, 0);
    reset = 1'b1;
    @(negedge clk);

    r = rand_vec(0);
    tbl[0]  = '{2'b00, fill(2'b01), fill(2'b01), fill(2'b10), 1'b0};
    tbl[1]  = '{2'b01, r, r, '0, 1'b0};
    tbl[2]  = '{2'b10, set_coef('0, 0, 2'b01), r, set_coef('0, 0, 2'b10), 1'b0};
    tbl[3]  = '{2'b00, fill(2'b01), '0, fill(2'b01), 1'b0};
    tbl[4]  = '{2'b11, fill(2'b01), r, fill(2'b10), 1'b0};
    tbl[5]  = '{2'b11, fill(2'b01), r, '0, 1'b0};
    tbl[6]  = '{2'b00, set_coef(fill(2'b01), 50, 2'b11), '0, set_coef(fill(2'b01), 50, 2'b00), 1'b1};
    tbl[7]  = '{2'b00, fill(2'b10), '0, fill(2'b10), 1'b0};
    tbl[8]  = '{2'b01, fill(2'b10), set_coef(fill(2'b01), 96, 2'b11),
                set_coef(fill(2'b01), 96, 2'b00), 1'b1};
    tbl[9]  = '{2'b11, set_coef(fill(2'b01), 7, 2'b11), '0,
                set_coef(set_coef(fill(2'b10), 96, 2'b01), 7, 2'b00), 1'b1};
    tbl[10] = '{2'b10, fill(2'b10), fill(2'b11), fill(2'b01), 1'b0};

    for (int k = 0; k < 11; k++)
      apply_all($sformatf("tbl%0d", k), tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].exp_c, tbl[k].exp_err);
    model_c = tbl[10].exp_c;

    for (int k = 0; k < 25; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = rand_vec(60);
      b  = rand_vec(60);
      model_op(op, a, b, model_c, exp, e);
      exp_q.push_back(exp);
      apply_all($sformatf("rnd%0d op%0d", k, op), op, a, b, exp_q[$], e);
      model_c = exp_q.pop_front();
    end

    // Starts during RUN carry a different op; only the first request may complete.
    launch(2'b00, fill(2'b01), fill(2'b01), 1'b0);
    n_done = 0;
    first  = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (if0.done) begin
        n_done++;
        if (first < 0) first = cyc;
      end
      if (cyc == 3 || cyc == 7) begin
        start = 1'b1;  op = 2'b10;  a = fill(2'b10);
      end else begin
        start = 1'b0;
      end
    end
    chk("hs done count", n_done, 1);
    chk("hs done lat", first, 13);
    chk("hs C", if0.C, fill(2'b10));

    launch(2'b00, fill(2'b01), '0, 1'b0);
    wait_main(lat);
    chk("b2b lat1", lat, 13);
    chk("b2b C1", if0.C, fill(2'b01));
    chk("b2b busy in done", if0.busy, 0);
    launch(2'b01, '0, fill(2'b01), 1'b0);
    wait_main(lat);
    chk("b2b lat2", lat, 13);
    chk("b2b C2", if0.C, fill(2'b10));

    launch(2'b00, set_coef(fill(2'b01), 3, 2'b11), fill(2'b01), 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst mid C", if0.C, '0);
    chk("rst mid busy", if0.busy, 0);
    chk("rst mid done", if0.done, 0);
    chk("rst mid aux C", if1.C, '0);
    @(negedge clk);
    reset = 1'b1;
    n_done = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (if0.done) n_done++;
    end
    chk("rst no done", n_done, 0);
    chk("rst err", if0.err, 0);
    launch(2'b00, fill(2'b10), fill(2'b10), 1'b0);
    wait_main(lat);
    chk("post rst lat", lat, 13);
    chk("post rst C", if0.C, fill(2'b01));
    chk("post rst err", if0.err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
